// File: rtl/lsu_mem_master_if.sv
// lsu_mem_master_if: core request/response handshake plus word-organised data-memory port.
interface lsu_mem_master_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic [31:0]       mem_rdata;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: byte-addressed RV32I load/store unit driving a word memory, read-modify-write for sub-word stores.
module lsu_mem_master #(
    parameter int ADDR_W = 10
) (
    input logic                clk,
    input logic                rst_n,
    lsu_mem_master_if.master   bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

    state_t      state;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;
    logic        legal;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;
    logic [31:0] merged;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

    always_comb begin
        legal = (bus.req_we ? bus.req_funct3 inside {3'b000, 3'b001, 3'b010}
                            : bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                && !(bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0])
                && !(bus.req_funct3 == 3'b010 && bus.req_addr[1:0] != 2'b00);
        byte_sel  = 8'(bus.mem_rdata >> {lane_q, 3'b000});
        half_sel  = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        load_val  = f3_q[1] ? bus.mem_rdata
                  : f3_q[0] ? {{16{half_sel[15] & ~f3_q[2]}}, half_sel}
                  : {{24{byte_sel[7] & ~f3_q[2]}}, byte_sel};
        lane_mask = f3_q[0] ? 32'h0000_FFFF << {lane_q[1], 4'b0000} : 32'h0000_00FF << {lane_q, 3'b000};
        lane_data = f3_q[0] ? {2{wdata_q}} : {4{wdata_q[7:0]}};
        merged    = (bus.mem_rdata & ~lane_mask) | (lane_data & lane_mask);
    end

    // Handshake and write strobe come from registered state only, so reset drops mem_we at once.
    assign bus.req_ready  = state == IDLE;
    assign bus.resp_valid = state == RESP;
    assign bus.mem_we     = state == MERGE || (state == ACCESS && we_q && f3_q == 3'b010);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            we_q           <= 1'b0;
            f3_q           <= '0;
            lane_q         <= '0;
            wdata_q        <= '0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    we_q    <= bus.req_we;
                    f3_q    <= bus.req_funct3;
                    lane_q  <= bus.req_addr[1:0];
                    wdata_q <= bus.req_wdata[15:0];
                    if (legal) begin
                        bus.mem_addr <= bus.req_addr[ADDR_W+1:2];
                        if (bus.req_we && bus.req_funct3 == 3'b010) bus.mem_wdata <= bus.req_wdata;
                        state <= ACCESS;
                    end else begin
                        bus.resp_rdata <= '0;
                        bus.resp_err   <= 1'b1;
                        state          <= RESP;
                    end
                end
                ACCESS: if (we_q && f3_q != 3'b010) begin
                    bus.mem_wdata <= merged;
                    state         <= MERGE;
                end else begin
                    bus.resp_rdata <= we_q ? '0 : load_val;
                    bus.resp_err   <= 1'b0;
                    state          <= RESP;
                end
                MERGE: begin
                    bus.resp_rdata <= '0;
                    bus.resp_err   <= 1'b0;
                    state          <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator between the single-stage RISC-V core's execute stage and the word-organised data memory (responder).
- Converts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses on the memory port.
  - Sub-word stores use a read-modify-write sequence.
  - Load data is extracted and sign/zero-extended.
- Flags misaligned or illegal requests without touching memory.
- A valid/ready request side and a one-cycle response pulse let the core stall on memory operations.

Parameters:
ADDR_W, 10, memory word-address width (memory depth = 2^ADDR_W words)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  core presents a memory request
req_ready  output  1  block can accept a request (high only in IDLE)
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  input  32  byte address
req_wdata  input  32  store data (sub-word data in LSBs)
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  misaligned or illegal funct3, valid with resp_valid
mem_addr  output  ADDR_W  word address to data memory
mem_wdata  output  32  write word to data memory
mem_we  output  1  write enable to data memory, sampled at clk rising edge
mem_rdata  input  32  asynchronous read data from data memory (reflects mem_addr same cycle)

Behaviour:
- One clock, clk. Reset is asynchronous, active-low (rst_n).
- Reset state: FSM=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0, all internal registers 0.
- Word index = req_addr[ADDR_W+1:2]; higher address bits are ignored (aliasing).
- Byte lane = req_addr[1:0].
- FSM states: IDLE, ACCESS, MERGE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we, funct3, addr and wdata.
  - Legality check:
    - H/HU require addr[0]=0.
    - W requires addr[1:0]=00.
    - Stores permit only funct3 000, 001 and 010.
  - Illegal request -> RESP with resp_err=1. Legal request -> ACCESS.
- ACCESS:
  - mem_addr = latched word index.
  - Load: capture mem_rdata, select the lane, sign-extend (B, H) or zero-extend (BU, HU) into resp_rdata -> RESP.
  - SW: mem_we=1, mem_wdata=wdata -> RESP.
  - SB/SH: register mem_rdata with the target lane replaced by wdata[7:0] or wdata[15:0] -> MERGE.
- MERGE: mem_we=1, mem_wdata=merged word, mem_addr unchanged -> RESP.
- RESP: resp_valid=1 for exactly one cycle, req_ready=0 -> IDLE.
- Latency from the accept edge (T) to resp_valid high:
  - Error: 1 cycle.
  - Load or SW: 2 cycles.
  - SB/SH: 3 cycles.
- Next accept possible in the cycle after RESP.
- mem_we is high in at most one cycle per store and never for loads or errors.
- req_ready=0 outside IDLE. req_valid while busy is ignored; the core holds the request until accepted.
- req_* inputs are ignored after the latch; changes during a transaction have no effect.
- resp_rdata and resp_err hold their values until the next response.
- mem_addr and mem_wdata hold between transactions.
- mem_we is decoded from the state register only (no input-to-mem_we combinational path).
- Reset mid-transaction (rst_n low in any state): immediate return to IDLE, mem_we drops asynchronously, no write occurs, no resp_valid is produced.
  - Reset in MERGE before the clk edge leaves the memory word unchanged.
- Byte lanes are little-endian: lane 0 = bits [7:0], lane 3 = bits [31:24]. Halfword lane 2 = bits [31:16].

Test Plan:
- Memory word 5 = 0x8899AABB. Load LB at addr 0x17 -> resp_valid at T+2, resp_rdata=0xFFFFFF88, resp_err=0. LBU at 0x17 -> 0x00000088. LH at 0x14 -> 0xFFFFAABB.
- SB wdata=0x000000CD at addr 0x15 over word 5=0x8899AABB -> mem_we high only at T+2 with mem_wdata=0x8899CDBB, resp_valid at T+3. A following LW at 0x14 returns 0x8899CDBB.
- SW 0xDEADBEEF at addr 0x0FFC -> mem_addr=0x3FF, single mem_we cycle at T+1. Addr 0x1000 aliases to word 0.
- LW at 0x22, SH at 0x13, funct3=011 -> resp_valid at T+1, resp_err=1, resp_rdata=0, mem_we never asserted.
- Back-to-back: req_valid held high for SW then LW -> second accept exactly one cycle after the first resp_valid. req_ready low during ACCESS, MERGE and RESP.
- rst_n pulled low during the MERGE cycle of an SH -> mem_we falls immediately, memory word unchanged, no resp_valid, req_ready=1 after release.
